cardinal_mem_arbiter: RTL and testbench
=======================================

Name: cardinal_mem_arbiter

Overview:
Round-robin arbiter that lets the four cardinal_cpu nodes share one single-ported data memory. It sits between the per-node dmem ports (en, WrEn, addr, data) and the shared memory.
- Stall outputs hold a losing or waiting CPU.
- Read data returns on a broadcast bus with a per-node valid strobe.
- Only one memory access is outstanding at a time.

Parameters:
NUM_REQ, 4, number of requesting CPU nodes
ADDR_W, 32, memory address width
DATA_W, 64, data word width
RD_LAT, 1, shared memory read latency in cycles from mem_en to valid mem_rdata (must be >= 1)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
req_en  input  [0:NUM_REQ-1]  per-node access request (dmem_En)
req_wr_en  input  [0:NUM_REQ-1]  per-node write flag (dmem_WrEn)
req_addr  input  [0:NUM_REQ*ADDR_W-1]  flattened addresses; node i occupies bits [i*ADDR_W : i*ADDR_W+ADDR_W-1]
req_wdata  input  [0:NUM_REQ*DATA_W-1]  flattened write data, same packing
req_stall  output  [0:NUM_REQ-1]  node i must hold its request and not advance
rsp_valid  output  [0:NUM_REQ-1]  one-cycle read-data strobe for node i
rsp_rdata  output  [0:DATA_W-1]  registered read data, shared by all nodes
mem_en  output  1  shared memory enable, registered
mem_wr_en  output  1  shared memory write enable, registered
mem_addr  output  [0:ADDR_W-1]  registered address
mem_wdata  output  [0:DATA_W-1]  registered write data
mem_rdata  input  [0:DATA_W-1]  shared memory read data

Behaviour:
- Bit 0 is the MSB on all buses.
- Requester rule: while req_stall[i]=1, node i holds req_en, req_wr_en, req_addr and req_wdata stable.
- Reset (reset=0 at an edge): state=ARB, rr_ptr=0, cnt=0, owner=0; mem_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_rdata=0.
  - Reset mid-read discards the read: no rsp_valid is ever produced for it.
- FSM states: ARB, RD_WAIT, RD_RESP.
- ARB:
  - Winner w = first i with req_en[i]=1, searching from rr_ptr upward modulo NUM_REQ.
  - If no request: mem_en=0 next cycle.
  - On any grant:
    - mem_en<=1, mem_wr_en<=req_wr_en[w], mem_addr<=addr(w), mem_wdata<=wdata(w).
    - rr_ptr<=(w+1) mod NUM_REQ.
  - Write grant: req_stall[w]=0 in the grant cycle; state stays ARB. Back-to-back writes sustain 1 per cycle.
  - Read grant: owner<=w, cnt<=RD_LAT, state<=RD_WAIT; req_stall[w] stays 1.
- RD_WAIT:
  - No grants are made; mem_en<=0.
  - If cnt=0: rsp_rdata<=mem_rdata, state<=RD_RESP. Otherwise cnt<=cnt-1.
- RD_RESP:
  - rsp_valid[owner]=1 for exactly this cycle and req_stall[owner]=0.
  - No grants; state<=ARB.
- Read timeline: granted in cycle N; mem_en high in N+1; mem_rdata sampled in N+1+RD_LAT; response in N+2+RD_LAT.
- req_stall[i] is combinational: req_en[i] AND NOT (write-granted-this-cycle(i) OR (state=RD_RESP AND owner=i)). It is 0 whenever req_en[i]=0.
- mem_en is a one-cycle pulse per grant. mem_addr and mem_wdata hold their last values when mem_en=0.
- Invariants:
  - At most one rsp_valid bit is high.
  - At most one write grant per cycle.
  - No grant while a read is outstanding.
- Fairness: any continuously requesting node is granted within NUM_REQ grants.

Decomposition:
- Package cardinal_mem_pkg holds:
  - state encoding (ARB=2'd0, RD_WAIT=2'd1, RD_RESP=2'd2);
  - default widths NUM_REQ/ADDR_W/DATA_W;
  - the slice-index helper for flattened buses.
- Sub-module cardinal_rr_arbiter: combinational, inputs req[0:NUM_REQ-1] and rr_ptr; outputs one-hot grant and encoded winner.

Test Plan:
- Reset: hold reset=0 for 2 cycles with all req_en=1 -> all outputs 0, no mem_en; first release cycle grants node 0.
- Single write: node 2 writes addr 0x10, data 0xDEADBEEF_00000001 -> req_stall[2]=0 in the same cycle; next cycle mem_en=1, mem_wr_en=1, mem_addr=0x10, mem_wdata matches; following cycle mem_en=0.
- Single read, RD_LAT=1, memory returns 0x1234 -> granted cycle N: req_stall[1]=1 in N..N+2; in N+3 rsp_valid[1]=1, rsp_rdata=0x1234, req_stall[1]=0.
- Four simultaneous writes after reset -> mem_addr issued in order node 0,1,2,3 on four consecutive cycles; each node's stall drops in its own grant cycle.
- Fairness: nodes 0 and 3 write continuously, node 1 issues one read -> grant order 0,1(read),3,0,3…; no writes during RD_WAIT/RD_RESP.
- Reset mid-read: reset=0 during RD_WAIT -> next cycle state=ARB, mem_en=0, no rsp_valid ever asserted for that read.

Source files
------------

// File: rtl/cardinal_mem_pkg.sv
// Shared types and defaults for the cardinal data-memory arbiter.
// Also holds the slice helper for the MSB-first flattened per-node buses.
package cardinal_mem_pkg;

  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned DATA_W_DEF  = 64;
  localparam int unsigned RD_LAT_DEF  = 1;

  typedef enum logic [1:0] {
    ARB     = 2'd0,
    RD_WAIT = 2'd1,
    RD_RESP = 2'd2
  } arb_state_e;

  // Lowest bit index of node idx's field in a flattened bus of width-bit fields.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/cardinal_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above rr_ptr, wrapping.
module cardinal_rr_arbiter
  import cardinal_mem_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [0:NUM_REQ-1] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [0:NUM_REQ-1] grant,
  output logic [PTR_W-1:0]   winner
);

  always_comb begin
    int unsigned idx;
    logic        found;
    idx    = 0;
    found  = 1'b0;
    grant  = '0;
    winner = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rr_ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        winner     = PTR_W'(idx);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cardinal_mem_arbiter.sv
// Round-robin arbiter sharing one single-ported data memory among the cardinal
// CPU nodes; writes retire at grant, reads hold the node until data returns.
module cardinal_mem_arbiter
  import cardinal_mem_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned RD_LAT  = RD_LAT_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [0:NUM_REQ-1]        req_en,
  input  logic [0:NUM_REQ-1]        req_wr_en,
  input  logic [0:NUM_REQ*ADDR_W-1] req_addr,
  input  logic [0:NUM_REQ*DATA_W-1] req_wdata,
  output logic [0:NUM_REQ-1]        req_stall,
  output logic [0:NUM_REQ-1]        rsp_valid,
  output logic [0:DATA_W-1]         rsp_rdata,
  output logic                      mem_en,
  output logic                      mem_wr_en,
  output logic [0:ADDR_W-1]         mem_addr,
  output logic [0:DATA_W-1]         mem_wdata,
  input  logic [0:DATA_W-1]         mem_rdata
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(RD_LAT + 1);

  arb_state_e         state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   owner;
  logic [CNT_W-1:0]   cnt;
  logic [0:NUM_REQ-1] grant;
  logic [PTR_W-1:0]   winner;
  logic [PTR_W-1:0]   ptr_next;
  logic               any_grant;
  logic [0:NUM_REQ-1] owner_onehot;

  cardinal_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req    (req_en),
    .rr_ptr (rr_ptr),
    .grant  (grant),
    .winner (winner)
  );

  // A grant only happens in ARB and never on a reset edge.
  always_comb begin
    any_grant = reset && (state == ARB) && (|grant);
    ptr_next  = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + PTR_W'(1);
  end

  // Stall releases on a same-cycle write grant or on the read response cycle.
  always_comb begin
    req_stall    = '0;
    owner_onehot = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      owner_onehot[i] = (owner == PTR_W'(i));
      req_stall[i]    = req_en[i] &
                        ~((any_grant & grant[i] & req_wr_en[i]) |
                          ((state == RD_RESP) & owner_onehot[i]));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ARB;
      rr_ptr    <= '0;
      cnt       <= '0;
      owner     <= '0;
      mem_en    <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      mem_en    <= 1'b0;
      rsp_valid <= '0;
      case (state)
        ARB: begin
          if (any_grant) begin
            mem_en    <= 1'b1;
            mem_wr_en <= req_wr_en[winner];
            mem_addr  <= req_addr[slice_lo(32'(winner), ADDR_W) +: ADDR_W];
            mem_wdata <= req_wdata[slice_lo(32'(winner), DATA_W) +: DATA_W];
            rr_ptr    <= ptr_next;
            if (!req_wr_en[winner]) begin
              owner <= winner;
              cnt   <= CNT_W'(RD_LAT);
              state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          // Count down the memory latency, then capture the read word.
          if (cnt == '0) begin
            rsp_rdata <= mem_rdata;
            rsp_valid <= owner_onehot;
            state     <= RD_RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RD_RESP: state <= ARB;
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_cardinal_mem_arbiter.sv
// Directed scoreboard bench for cardinal_mem_arbiter with a one-cycle-latency memory model.
module tb_cardinal_mem_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [63:0] data;
  } mem_exp_t;

  typedef struct {
    logic [3:0]  vld;
    logic [63:0] data;
  } rsp_exp_t;

  logic                 clk;
  logic                 reset;
  logic [0:NR-1]        req_en;
  logic [0:NR-1]        req_wr_en;
  logic [0:NR*AW-1]     req_addr;
  logic [0:NR*DW-1]     req_wdata;
  logic [0:NR-1]        req_stall;
  logic [0:NR-1]        rsp_valid;
  logic [0:DW-1]        rsp_rdata;
  logic                 mem_en;
  logic                 mem_wr_en;
  logic [0:AW-1]        mem_addr;
  logic [0:DW-1]        mem_wdata;
  logic [0:DW-1]        mem_rdata;

  int checks   = 0;
  int failures = 0;

  mem_exp_t exp_q[$];
  rsp_exp_t rsp_q[$];
  mem_exp_t me;
  rsp_exp_t re;
  logic [63:0] mem_model [logic [31:0]];

  cardinal_mem_arbiter #(
    .NUM_REQ (NR),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .RD_LAT  (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_en    (req_en),
    .req_wr_en (req_wr_en),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_stall (req_stall),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_en    (mem_en),
    .mem_wr_en (mem_wr_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared memory: writes commit at the edge, reads return one cycle after mem_en.
  initial mem_rdata = '0;
  always @(posedge clk) begin
    if (mem_en === 1'b1) begin
      if (mem_wr_en === 1'b1) mem_model[32'(mem_addr)] = 64'(mem_wdata);
      else mem_rdata <= mem_model.exists(32'(mem_addr)) ? mem_model[32'(mem_addr)] : 64'h0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every memory pulse and read response is matched in order.
  always @(negedge clk) begin
    if (mem_en === 1'b1) begin
      check("mem_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        me = exp_q.pop_front();
        check("mem_wr_en", 64'(mem_wr_en), 64'(me.wr));
        check("mem_addr", 64'(mem_addr), 64'(me.addr));
        if (me.wr) check("mem_wdata", 64'(mem_wdata), me.data);
      end
    end
    if ((|rsp_valid) === 1'b1) begin
      check("rsp_onehot", 64'($onehot0(rsp_valid)), 64'(1));
      check("rsp_expected", 64'(rsp_q.size() != 0), 64'(1));
      if (rsp_q.size() != 0) begin
        re = rsp_q.pop_front();
        check("rsp_valid", 64'(rsp_valid), 64'(re.vld));
        check("rsp_rdata", 64'(rsp_rdata), re.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_stall(input string tag, input logic [3:0] e);
    #1;
    check(tag, 64'(req_stall), 64'(e));
  endtask

  task automatic set_req(input int i, input logic wr, input logic [31:0] a, input logic [63:0] d);
    req_en[i]               = 1'b1;
    req_wr_en[i]            = wr;
    req_addr[i*AW +: AW]    = a;
    req_wdata[i*DW +: DW]   = d;
  endtask

  task automatic clr_req(input int i);
    req_en[i]    = 1'b0;
    req_wr_en[i] = 1'b0;
  endtask

  task automatic push_mem(input logic wr, input logic [31:0] a, input logic [63:0] d);
    mem_exp_t t;
    t.wr = wr; t.addr = a; t.data = d;
    exp_q.push_back(t);
  endtask

  task automatic push_rsp(input logic [3:0] v, input logic [63:0] d);
    rsp_exp_t t;
    t.vld = v; t.data = d;
    rsp_q.push_back(t);
  endtask

  initial begin
    reset     = 1'b0;
    req_en    = '0;
    req_wr_en = '0;
    req_addr  = '0;
    req_wdata = '0;
    mem_model[32'h20] = 64'h1234;

    // Reset held two cycles with every node requesting a write.
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 32'h100 + 32'(i), 64'hA000 + 64'(i));
    step();
    check("rst_mem_en", 64'(mem_en), 64'(0));
    check("rst_mem_wr_en", 64'(mem_wr_en), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    chk_stall("rst_stall", 4'b1111);
    step();
    check("rst2_mem_en", 64'(mem_en), 64'(0));

    // Release: four writes granted in node order, one per cycle.
    reset = 1'b1;
    for (int i = 0; i < 4; i++) push_mem(1'b1, 32'h100 + 32'(i), 64'hA000 + 64'(i));
    chk_stall("quad_g0", 4'b0111);
    step(); clr_req(0);
    chk_stall("quad_g1", 4'b0011);
    step(); clr_req(1);
    chk_stall("quad_g2", 4'b0001);
    step(); clr_req(2);
    chk_stall("quad_g3", 4'b0000);
    step(); clr_req(3);
    step();
    check("idle_mem_en", 64'(mem_en), 64'(0));

    // Single write from node 2.
    set_req(2, 1'b1, 32'h10, 64'hDEADBEEF_00000001);
    push_mem(1'b1, 32'h10, 64'hDEADBEEF_00000001);
    chk_stall("wr_stall_same_cycle", 4'b0000);
    step(); clr_req(2);
    check("wr_mem_en", 64'(mem_en), 64'(1));
    step();
    check("wr_mem_en_pulse", 64'(mem_en), 64'(0));
    check("wr_addr_hold", 64'(mem_addr), 64'h10);

    // Single read from node 1: stalled three cycles, response in the fourth.
    set_req(1, 1'b0, 32'h20, 64'h0);
    push_mem(1'b0, 32'h20, 64'h0);
    push_rsp(4'b0100, 64'h1234);
    chk_stall("rd_stall_n0", 4'b0100);
    step();
    chk_stall("rd_stall_n1", 4'b0100);
    step();
    chk_stall("rd_stall_n2", 4'b0100);
    step();
    chk_stall("rd_stall_n3", 4'b0000);
    check("rd_rsp_valid", 64'(rsp_valid), 64'h4);
    check("rd_rsp_rdata", 64'(rsp_rdata), 64'h1234);
    clr_req(1);
    step();
    check("rd_rsp_pulse", 64'(rsp_valid), 64'(0));

    // Reset while node 0's read waits on memory: the response must never appear.
    set_req(0, 1'b0, 32'h20, 64'h0);
    push_mem(1'b0, 32'h20, 64'h0);
    chk_stall("rstrd_grant", 4'b1000);
    step();
    chk_stall("rstrd_wait", 4'b1000);
    reset = 1'b0;
    step();
    reset = 1'b1;
    clr_req(0);
    check("rstrd_mem_en", 64'(mem_en), 64'(0));
    check("rstrd_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rstrd_mem_addr", 64'(mem_addr), 64'(0));
    for (int i = 0; i < 4; i++) begin
      step();
      check("rstrd_no_rsp", 64'(rsp_valid), 64'(0));
    end

    // Fairness: nodes 0 and 3 stream writes, node 1 slips in one read.
    set_req(0, 1'b1, 32'h200, 64'hB200);
    set_req(1, 1'b0, 32'h20, 64'h0);
    set_req(3, 1'b1, 32'h300, 64'hB300);
    push_mem(1'b1, 32'h200, 64'hB200);
    push_mem(1'b0, 32'h20, 64'h0);
    push_mem(1'b1, 32'h300, 64'hB300);
    push_mem(1'b1, 32'h201, 64'hB201);
    push_mem(1'b1, 32'h301, 64'hB301);
    push_mem(1'b1, 32'h202, 64'hB202);
    push_rsp(4'b0100, 64'h1234);
    chk_stall("fair_f0", 4'b0101);
    step(); set_req(0, 1'b1, 32'h201, 64'hB201);
    chk_stall("fair_f1_read", 4'b1101);
    step();
    chk_stall("fair_f2_wait", 4'b1101);
    step();
    chk_stall("fair_f3_wait", 4'b1101);
    step();
    chk_stall("fair_f4_resp", 4'b1001);
    step(); clr_req(1);
    chk_stall("fair_f5_g3", 4'b1000);
    step(); set_req(3, 1'b1, 32'h301, 64'hB301);
    chk_stall("fair_f6_g0", 4'b0001);
    step(); set_req(0, 1'b1, 32'h202, 64'hB202);
    chk_stall("fair_f7_g3", 4'b1000);
    step(); clr_req(3);
    chk_stall("fair_f8_g0", 4'b0000);
    step(); clr_req(0);
    step();
    step();
    check("idle_end_mem_en", 64'(mem_en), 64'(0));

    check("mem_q_drained", 64'(exp_q.size()), 64'(0));
    check("rsp_q_drained", 64'(rsp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
